// File: rtl/count_event_tracker.sv
// Samples an up/down counter and records reversal, wrap and jump events.
// Jump events are built only when TRACKER_JUMP_DETECT_EN is defined.
module count_event_tracker #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_code,
  output logic [WIDTH-1:0] evt_value,
  output logic             dir,
  output logic [WIDTH-1:0] peak_max,
  output logic [WIDTH-1:0] peak_min,
  output logic [7:0]       step_cnt,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX  = '1;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_REV  = 3'd1;
  localparam logic [2:0] C_WRAP = 3'd2;
  localparam logic [2:0] C_JUMP = 3'd3;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prev_n;
  logic             dir_n;
  logic [WIDTH-1:0] pmax_n;
  logic [WIDTH-1:0] pmin_n;
  logic [7:0]       step_n;
  logic             ovf_n;
  logic [2:0]       code_n;
  logic [WIDTH-1:0] val_n;

  logic [WIDTH-1:0] delta;
  logic             is_zero;
  logic             is_up;
  logic             is_dn;
  logic             is_step;
  logic             is_jmp;
  logic             is_rev;
  logic             is_wrap;
  logic             sample;
  logic [2:0]       ev_code;
  logic             ev;

  assign evt_valid = (state == HOLD);

  // Classify the step between the previous and the current sample.
  always_comb begin
    delta   = count - prev;
    is_zero = (delta == ZERO);
    is_up   = (delta == ONE);
    is_dn   = (delta == MAX);
    is_step = is_up | is_dn;
`ifdef TRACKER_JUMP_DETECT_EN
    is_jmp  = !is_zero && !is_step;
`else
    is_jmp  = 1'b0;
`endif
    is_rev  = is_step && (is_up != dir)
              && (step_cnt != 8'd0);
    is_wrap = (is_up && (prev == MAX))
              || (is_dn && (prev == ZERO));
    sample  = enable && (state != IDLE);
    ev_code = C_NONE;
    if (is_jmp) begin
      ev_code = C_JUMP;
    end else if (is_rev) begin
      ev_code = C_REV;
    end else if (is_wrap) begin
      ev_code = C_WRAP;
    end
    ev = sample && (ev_code != C_NONE);
  end

  // Next-state, statistics and event record logic.
  always_comb begin
    state_n = state;
    prev_n  = prev;
    dir_n   = dir;
    pmax_n  = peak_max;
    pmin_n  = peak_min;
    step_n  = step_cnt;
    ovf_n   = overflow;
    code_n  = evt_code;
    val_n   = evt_value;
    unique case (state)
      IDLE: begin
        if (enable) begin
          prev_n  = count;
          pmax_n  = count;
          pmin_n  = count;
          state_n = TRACK;
        end
      end
      TRACK: begin
        if (ev) begin
          state_n = HOLD;
          code_n  = ev_code;
          val_n   = count;
        end
      end
      HOLD: begin
        if (evt_ready) begin
          if (ev) begin
            code_n = ev_code;
            val_n  = count;
          end else begin
            state_n = TRACK;
            code_n  = C_NONE;
            val_n   = ZERO;
          end
        end else if (ev) begin
          ovf_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (sample) begin
      prev_n = count;
      if (count > peak_max) begin
        pmax_n = count;
      end
      if (count < peak_min) begin
        pmin_n = count;
      end
      if ((is_step || is_jmp)
          && (step_cnt != 8'hFF)) begin
        step_n = step_cnt + 8'd1;
      end
      if (is_step) begin
        dir_n = is_up;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= ZERO;
      dir       <= 1'b1;
      peak_max  <= ZERO;
      peak_min  <= ZERO;
      step_cnt  <= 8'd0;
      overflow  <= 1'b0;
      evt_code  <= C_NONE;
      evt_value <= ZERO;
    end else begin
      state     <= state_n;
      prev      <= prev_n;
      dir       <= dir_n;
      peak_max  <= pmax_n;
      peak_min  <= pmin_n;
      step_cnt  <= step_n;
      overflow  <= ovf_n;
      evt_code  <= code_n;
      evt_value <= val_n;
    end
  end

endmodule

// File: tb/tb_count_event_tracker.sv
// Scoreboard bench for count_event_tracker.
// Directed vectors; a negedge monitor checks each consumed record.
module tb_count_event_tracker;

  localparam int W = 5;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] count;
  logic         evt_valid;
  logic         evt_ready;
  logic [2:0]   evt_code;
  logic [W-1:0] evt_value;
  logic         dir;
  logic [W-1:0] peak_max;
  logic [W-1:0] peak_min;
  logic [7:0]   step_cnt;
  logic         overflow;

  typedef struct packed {
    logic [2:0]   code;
    logic [W-1:0] val;
  } rec_t;

  rec_t exp_q[$];
  int   checks;
  int   fails;

  count_event_tracker #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .count(count),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code(evt_code),
    .evt_value(evt_value),
    .dir(dir),
    .peak_max(peak_max),
    .peak_min(peak_min),
    .step_cnt(step_cnt),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Monitor: every record the consumer accepts must match the queue head.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_event: got code %0d value %0d expected none",
                 evt_code, evt_value);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("evt_code", int'(evt_code), int'(e.code));
        chk("evt_value", int'(evt_value), int'(e.val));
      end
    end
  end

  task automatic smp(input int c);
    enable = 1'b1;
    count  = W'(c);
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic push(input int code, input int v);
    rec_t e;
    e.code = 3'(code);
    e.val  = W'(v);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    enable = 1'b0;
    reset  = 1'b1;
    #2;
    reset  = 1'b0;
  endtask

  task automatic drained(input string name);
    @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    count     = '0;
    evt_ready = 1'b1;
    #12;
    reset = 1'b0;
    #1;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_code", int'(evt_code), 0);
    chk("rst_value", int'(evt_value), 0);
    chk("rst_dir", int'(dir), 1);
    chk("rst_pmax", int'(peak_max), 0);
    chk("rst_pmin", int'(peak_min), 0);
    chk("rst_steps", int'(step_cnt), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Plain up count.
    @(posedge clk);
    #1;
    smp(3);
    chk("idle_pmax", int'(peak_max), 3);
    chk("idle_steps", int'(step_cnt), 0);
    smp(4);
    smp(5);
    smp(6);
    chk("up_steps", int'(step_cnt), 3);
    chk("up_dir", int'(dir), 1);
    chk("up_pmax", int'(peak_max), 6);
    chk("up_pmin", int'(peak_min), 3);
    chk("up_valid", int'(evt_valid), 0);

    // Disabled edges change nothing.
    count = 5'd20;
    @(posedge clk);
    #1;
    chk("dis_pmax", int'(peak_max), 6);
    chk("dis_steps", int'(step_cnt), 3);
    drained("up_drain");

    // Reversal.
    do_reset();
    smp(5);
    smp(6);
    smp(7);
    push(1, 6);
    smp(6);
    chk("rev_dir", int'(dir), 0);
    chk("rev_steps", int'(step_cnt), 3);
    drained("rev_drain");
    chk("rev_clear", int'(evt_valid), 0);
    chk("rev_code0", int'(evt_code), 0);

    // Upward wrap.
    do_reset();
    smp(30);
    smp(31);
    push(2, 0);
    smp(0);
    drained("wrapu_drain");

    // Downward wrap.
    do_reset();
    smp(1);
    smp(0);
    push(2, 31);
    smp(31);
    chk("wrapd_dir", int'(dir), 0);
    drained("wrapd_drain");

    // Record held without ready; second event dropped.
    do_reset();
    evt_ready = 1'b0;
    smp(5);
    smp(6);
    push(1, 5);
    smp(5);
    smp(6);
    chk("hold_valid", int'(evt_valid), 1);
    chk("hold_code", int'(evt_code), 1);
    chk("hold_value", int'(evt_value), 5);
    chk("hold_ovf", int'(overflow), 1);
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_consumed", int'(evt_valid), 0);
    chk("hold_ovf_sticky", int'(overflow), 1);
    drained("hold_drain");

    // Non-unit jump.
    do_reset();
    smp(4);
`ifdef TRACKER_JUMP_DETECT_EN
    push(3, 9);
    smp(9);
    chk("jump_steps", int'(step_cnt), 1);
`else
    smp(9);
    chk("jump_steps", int'(step_cnt), 0);
    chk("jump_valid", int'(evt_valid), 0);
`endif
    chk("jump_dir", int'(dir), 1);
    chk("jump_pmax", int'(peak_max), 9);
    drained("jump_drain");

    // Reset in the middle of a pending record.
    do_reset();
    evt_ready = 1'b0;
    smp(5);
    smp(6);
    smp(5);
    chk("mid_pending", int'(evt_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_valid", int'(evt_valid), 0);
    chk("mid_steps", int'(step_cnt), 0);
    chk("mid_code", int'(evt_code), 0);
    #1;
    reset = 1'b0;
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    smp(7);
    chk("post_valid", int'(evt_valid), 0);
    chk("post_steps", int'(step_cnt), 0);
    chk("post_pmin", int'(peak_min), 7);
    smp(8);
    chk("post_up_steps", int'(step_cnt), 1);
    chk("post_up_valid", int'(evt_valid), 0);
    drained("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/count_event_tracker.md
COUNT_EVENT_TRACKER -- requirements
Module: count_event_tracker

Interface
REQ-001 Parameter WIDTH, default 5, width of the sampled count bus.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  sample qualifier; count is sampled only on edges where enable=1.
REQ-005 count  input  WIDTH  count value produced by the upstream up/down counter.
REQ-006 evt_valid  output  1  event record pending.
REQ-007 evt_ready  input  1  consumer accepts the pending record when evt_valid=1.
REQ-008 evt_code  output  3  1=reversal, 2=wrap, 3=jump; 0 when no record pending.
REQ-009 evt_value  output  WIDTH  count value that triggered the pending event.
REQ-010 dir  output  1  last step direction, 1=up, 0=down.
REQ-011 peak_max / peak_min  output  WIDTH each  largest / smallest sampled count since reset.
REQ-012 step_cnt  output  8  saturating number of non-zero steps since reset.
REQ-013 overflow  output  1  sticky: an event was dropped because a record was already pending.

Function
REQ-014 Control FSM states SHALL be IDLE (no sample yet), TRACK (no record pending) and HOLD (record pending).
REQ-015 IDLE, enable=1: load prev, peak_max and peak_min with count; go to TRACK; no event; dir unchanged.
REQ-016 TRACK/HOLD, enable=1: delta = (count - prev) mod 2^WIDTH; then prev <= count.
REQ-017 delta=0: hold, no step, no event; delta=1: up step; delta=2^WIDTH-1: down step; any other delta: jump.
REQ-018 Up or down step: increment step_cnt (saturating at 255) and set dir to the step direction.
REQ-019 Reversal: step direction differs from dir, and at least one step has occurred since reset.
REQ-020 Wrap: up step from 2^WIDTH-1 to 0, or down step from 0 to 2^WIDTH-1.
REQ-021 Jump: increments step_cnt; leaves dir unchanged.
REQ-022 When several events coincide on one sample, priority SHALL be jump > reversal > wrap; only one record is generated.
REQ-023 peak_max and peak_min SHALL update on every sample in TRACK/HOLD using unsigned compare.
REQ-024 A generated event SHALL appear on evt_valid, evt_code and evt_value registered.
REQ-025 Latency: outputs are valid in the cycle after the sampling edge (one-cycle latency).
REQ-026 Handshake: a record is consumed on a rising edge with evt_valid=1 and evt_ready=1.
REQ-027 While evt_valid=1 and the record is not consumed, evt_code and evt_value SHALL hold stable.
REQ-028 Consume with no new event: go to TRACK; evt_valid=0; evt_code=0.
REQ-029 Consume and a new event on the same edge: load the new record and stay in HOLD; no overflow.
REQ-030 New event in HOLD without consume: drop the new event; keep the old record; set overflow.
REQ-031 enable=0: no sample, no statistic or event generation; the handshake still operates.

Reset
REQ-032 Asserting reset SHALL immediately force IDLE, including mid-handshake; any pending record is discarded.
REQ-033 Reset values: evt_valid=0, evt_code=0, evt_value=0, dir=1, peak_max=0, peak_min=0, step_cnt=0, overflow=0, prev=0.
REQ-034 The first enabled edge after reset deassertion SHALL be treated as the IDLE sample.

Configuration
REQ-035 Macro TRACKER_JUMP_DETECT_EN defined: jump events are generated as in REQ-017/021/022.
REQ-036 Macro absent: a non-unit, non-zero delta generates no record and does not count as a step.
REQ-037 Macro absent: such a delta only resynchronises prev and updates the peaks; evt_code 3 is never produced.

Verification
REQ-038 reset, then enable=1, count 3,4,5,6, evt_ready=1 -> step_cnt=3, dir=1, peak_max=6, peak_min=3, no event.
REQ-039 count 5,6,7,6, evt_ready=1 -> single cycle with evt_valid=1, evt_code=1, evt_value=6; dir=0.
REQ-040 up steps 30,31,0 -> evt_code=2, evt_value=0; down steps 1,0,31 -> evt_code=2, evt_value=31.
REQ-041 evt_ready=0, count 5,6,5,6 -> first reversal held, evt_value=5, overflow=1.
REQ-041a then evt_ready=1 -> record consumed, evt_valid=0.
REQ-042 count 4 then 9 -> with macro: evt_code=3, evt_value=9; without macro: no event, step_cnt unchanged.
REQ-043 evt_valid=1 pending, reset pulsed between edges -> evt_valid=0 and step_cnt=0 immediately.
REQ-043a next enabled sample -> no event.
